// File: rtl/regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_writeback_arbiter
//
// Merges two producers of register-file writes onto a single write port:
//   - the ALU, which has priority and writes one cycle after its handshake;
//   - the load unit, whose results are buffered in a small FIFO and drained
//     whenever the ALU leaves the write port idle.
// A starvation counter guarantees forward progress for loads: once the
// FIFO head has lost STARVE_LIMIT arbitrations in a row, the ALU is stalled
// (alu_ready = 0) for one cycle and the head is written instead.
// Writes to x0 are never issued: an ALU x0 result is accepted and dropped
// (the FIFO head gets the slot), and a load x0 result is accepted but not
// queued.
//
// Handshake semantics (both sources): a transfer happens at a rising clk
// edge where valid && ready. ready never depends on valid of the same
// source; a producer may hold valid with stable payload until it sees ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/rd/data        ALU result offer
//   alu_ready                ALU result accepted (combinational)
//   ld_valid/rd/data         load result offer
//   ld_ready                 load result accepted (combinational)
//   write_enable/addr/data   registered register-file write port
//   ld_count                 registered FIFO occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module regfile_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_rd,
  input  logic [31:0]              ld_data,
  output logic                     ld_ready,
  output logic                     write_enable,
  output logic [4:0]               write_addr,
  output logic [31:0]              write_data,
  output logic [$clog2(DEPTH):0]   ld_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]    LIMIT      = 4'(STARVE_LIMIT);

  // Each FIFO entry is {rd, data}.
  logic [36:0]   fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    starve_cnt;

  logic        fifo_empty;
  logic        fifo_full;
  logic        force_ld;
  logic        push;
  logic        pop;
  logic        alu_win;
  logic [36:0] head;

  assign fifo_empty = (ld_count == '0);
  assign fifo_full  = (ld_count == FULL_COUNT);
  assign head       = fifo_mem[rd_ptr];

  // The head has waited long enough: it takes the port and the ALU stalls.
  assign force_ld = (starve_cnt == LIMIT) && !fifo_empty;

  // Both readies are forced high during reset; the handshakes they would
  // complete are ignored because push/pop/alu_win are gated by rst.
  assign alu_ready = rst | !force_ld;

  // Fullness is judged on the occupancy at the start of the cycle, so a
  // same-cycle pop never makes room for a push while full.
  assign ld_ready = rst | !fifo_full;

  // A load to x0 completes its handshake but is not stored.
  assign push = !rst && ld_valid && !fifo_full && (ld_rd != 5'd0);

  // Winner selection. An ALU x0 result is accepted and dropped; the write
  // slot it would have used is handed to the FIFO head.
  always_comb begin
    pop     = 1'b0;
    alu_win = 1'b0;
    if (!rst) begin
      if (force_ld) begin
        pop = 1'b1;
      end else if (alu_valid) begin
        if (alu_rd != 5'd0) begin
          alu_win = 1'b1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end
      end else if (!fifo_empty) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers
  // and ld_count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {ld_rd, ld_data};
    end
  end

  // Pointers, occupancy and starvation counter. Pointers are AW bits wide
  // and DEPTH is a power of two, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      ld_count   <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   ld_count <= ld_count + CW'(1);
        2'b01:   ld_count <= ld_count - CW'(1);
        default: ld_count <= ld_count;
      endcase
      // Counts cycles the current head sat in the FIFO without being
      // written; a fresh push into an empty FIFO starts from zero.
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Registered write port. Address and data hold when no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= 5'd0;
      write_data   <= 32'd0;
    end else if (alu_win) begin
      write_enable <= 1'b1;
      write_addr   <= alu_rd;
      write_data   <= alu_data;
    end else if (pop) begin
      write_enable <= 1'b1;
      write_addr   <= head[36:32];
      write_data   <= head[31:0];
    end else begin
      write_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_arbiter
//
// Directed scenarios followed by randomized traffic. A behavioural model
// (load results as a queue, a starvation count as an int) predicts the
// readies, the next-cycle write and the occupancy for every cycle.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(DEPTH) + 1;

  // ---- clock / reset -----------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          alu_ready;
  logic          ld_valid;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          write_enable;
  logic [4:0]    write_addr;
  logic [31:0]   write_data;
  logic [CW-1:0] ld_count;

  regfile_writeback_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .ld_count    (ld_count)
  );

  // ---- scoreboard / model state -------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  logic [36:0] fifo_q[$];   // loads waiting, {rd, data}
  logic [36:0] exp_q[$];    // write expected on the next cycle
  int          starve = 0;
  logic [4:0]  last_addr = 5'd0;
  logic [31:0] last_data = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- driver: one clock cycle, model prediction and checks --------------
  task automatic step(input logic r, input logic av, input logic [4:0] ard,
                      input logic [31:0] adat, input logic lv,
                      input logic [4:0] lrd, input logic [31:0] ldat,
                      output logic a_hs, output logic l_hs);
    logic        exp_ld_ready;
    logic        exp_alu_ready;
    logic        force_win;
    logic        do_pop;
    int          size_before;
    logic [36:0] w;

    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    #1;

    size_before   = fifo_q.size();
    force_win     = !r && (starve == STARVE_LIMIT) && (size_before > 0);
    exp_ld_ready  = r || (size_before != DEPTH);
    exp_alu_ready = r || !force_win;
    check_eq("alu_ready", alu_ready, exp_alu_ready);
    check_eq("ld_ready", ld_ready, exp_ld_ready);

    a_hs = av && exp_alu_ready && !r;
    l_hs = lv && exp_ld_ready && !r;

    if (r) begin
      fifo_q.delete();
      exp_q.delete();
      starve    = 0;
      last_addr = 5'd0;
      last_data = 32'd0;
    end else begin
      do_pop = 1'b0;
      if (force_win) begin
        do_pop = 1'b1;
      end else if (av && ard != 5'd0) begin
        exp_q.push_back({ard, adat});
      end else if (size_before > 0) begin
        do_pop = 1'b1;   // ALU idle, or ALU offered x0 and was discarded
      end
      if (do_pop) exp_q.push_back(fifo_q.pop_front());
      if (l_hs && lrd != 5'd0) fifo_q.push_back({lrd, ldat});
      if (size_before == 0 || do_pop) starve = 0;
      else if (starve < STARVE_LIMIT) starve++;
    end

    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check_eq("write_enable", write_enable, 1'b1);
      check_eq("write_addr", write_addr, w[36:32]);
      check_eq("write_data", write_data, w[31:0]);
      last_addr = w[36:32];
      last_data = w[31:0];
    end else begin
      check_eq("write_enable", write_enable, 1'b0);
      check_eq("write_addr_hold", write_addr, last_addr);
      check_eq("write_data_hold", write_data, last_data);
    end
    check_eq("no_x0_write", (write_enable && write_addr == 5'd0), 1'b0);
    check_eq("ld_count", ld_count, fifo_q.size());
  endtask

  // Presents one load and holds it until accepted, ALU kept busy meanwhile.
  task automatic load_held(input logic [4:0] lrd, input logic [31:0] ldat,
                           input logic av, input logic [4:0] ard);
    logic a_hs, l_hs;
    int   tries;
    tries = 0;
    l_hs  = 1'b0;
    while (!l_hs && tries < 20) begin
      step(1'b0, av, ard, $urandom, 1'b1, lrd, ldat, a_hs, l_hs);
      tries++;
    end
    check_eq("load_accept_bound", l_hs, 1'b1);
  endtask

  task automatic idle(input int n);
    logic a_hs, l_hs;
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a_hs, l_hs);
  endtask

  task automatic do_reset();
    logic a_hs, l_hs;
    step(1'b1, 1'b1, 5'd6, 32'h1234, 1'b1, 5'd6, 32'h5678, a_hs, l_hs);
  endtask

  // ---- stimulus ------------------------------------------------------------
  initial begin
    logic a_hs, l_hs;
    logic [4:0] rr;
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    do_reset();

    // Single ALU write
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, a_hs, l_hs);
    check_eq("alu_hs", a_hs, 1'b1);
    idle(2);

    // Fill: five loads with the ALU continuously busy
    for (int i = 1; i <= 5; i++)
      load_held(5'(i), 32'h100 + 32'(i), 1'b1, 5'd2);
    idle(8);

    // Starvation: one load head, ALU held on rd 3
    do_reset();
    step(1'b0, 1'b1, 5'd3, 32'hA0, 1'b1, 5'd7, 32'h11, a_hs, l_hs);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 5'd3, 32'hA1 + 32'(i), 1'b0, 5'd0, 32'd0, a_hs, l_hs);
    idle(2);

    // x0 handling: ALU x0 hands the slot to the head; load x0 not queued
    step(1'b0, 1'b1, 5'd3, 32'hB0, 1'b1, 5'd9, 32'h99, a_hs, l_hs);
    step(1'b0, 1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0, a_hs, l_hs);
    check_eq("alu_x0_accept", a_hs, 1'b1);
    step(1'b0, 1'b1, 5'd4, 32'hB1, 1'b1, 5'd0, 32'h77, a_hs, l_hs);
    check_eq("ld_x0_accept", l_hs, 1'b1);
    idle(2);

    // Reset mid-operation with three queued loads
    for (int i = 1; i <= 3; i++)
      load_held(5'(i + 10), 32'hC0 + 32'(i), 1'b1, 5'd4);
    do_reset();
    idle(4);

    // Full with pop on an ALU idle cycle
    for (int i = 1; i <= 4; i++)
      load_held(5'(i + 20), 32'hD0 + 32'(i), 1'b1, 5'd8);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'hE0, a_hs, l_hs);
    check_eq("full_push_blocked", l_hs, 1'b0);
    idle(6);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 3;
      rr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(($urandom_range(0, 150) == 0),
           ($urandom_range(0, 3) < dens + 1), rr, $urandom,
           ($urandom_range(0, 3) < 3 - dens),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom, a_hs, l_hs);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
REGFILE_WRITEBACK_ARBITER -- requirements
Module: regfile_writeback_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning load-result FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost arbitrations before the load head is forced to win (range 1..15).
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port alu_valid  in  1  meaning an ALU result is offered.
REQ-006 SHALL have port alu_rd  in  5  meaning the ALU destination register.
REQ-007 SHALL have port alu_data  in  32  meaning the ALU result.
REQ-008 SHALL have port alu_ready  out  1  meaning the ALU result is accepted this cycle; combinational.
REQ-009 SHALL have port ld_valid  in  1  meaning a load result is offered.
REQ-010 SHALL have port ld_rd  in  5  meaning the load destination register.
REQ-011 SHALL have port ld_data  in  32  meaning the load result.
REQ-012 SHALL have port ld_ready  out  1  meaning the load result is accepted this cycle; combinational.
REQ-013 SHALL have port write_enable  out  1  meaning the register-file write strobe; registered.
REQ-014 SHALL have port write_addr  out  5  meaning the register-file write address; registered.
REQ-015 SHALL have port write_data  out  32  meaning the register-file write data; registered.
REQ-016 SHALL have port ld_count  out  clog2(DEPTH)+1  meaning current FIFO occupancy; registered.

Function
REQ-017 SHALL complete a handshake on a source only in a cycle where its valid and ready are both 1 at the clk edge.
REQ-018 SHALL set ld_ready = (ld_count != DEPTH); a pop in the same cycle SHALL NOT free a slot for a push while full.
REQ-019 SHALL push {ld_rd, ld_data} into the FIFO on a load handshake with ld_rd != 0; with ld_rd == 0 the handshake completes and nothing is pushed.
REQ-020 SHALL keep a starvation counter that increments each cycle the FIFO is non-empty and not popped, saturates at STARVE_LIMIT, and clears on any pop or when the FIFO is empty.
REQ-021 SHALL force a FIFO win (force = 1) when the counter equals STARVE_LIMIT and the FIFO is non-empty.
REQ-022 SHALL set alu_ready = !force.
REQ-023 SHALL select the winner as follows each cycle: if force, pop the FIFO head; else if alu_valid, the ALU; else if the FIFO is non-empty, pop the FIFO head; else none.
REQ-024 SHALL treat an ALU handshake with alu_rd == 0 as accepted and discarded, and in that cycle SHALL pop the FIFO head if it is non-empty.
REQ-025 SHALL register the winner: next cycle write_enable = 1, write_addr = winner rd, write_data = winner data; with no winner, write_enable = 0 and addr/data hold their previous values.
REQ-026 SHALL give a latency of exactly 1 cycle from an ALU handshake to write_enable, and at least 2 cycles from a load handshake (push, then pop).
REQ-027 SHALL, on a simultaneous push and pop, update ld_count by net zero and keep FIFO order; pointers wrap modulo DEPTH.
REQ-028 SHALL never drive write_enable = 1 with write_addr == 0.
REQ-029 SHALL preserve FIFO order among loads; ordering between ALU and load results to the same rd is the producers' responsibility.

Reset
REQ-030 SHALL, while rst = 1 at a clk edge, clear the FIFO pointers, ld_count = 0, starvation counter = 0, write_enable = 0, write_addr = 0 and write_data = 0.
REQ-031 SHALL drop in-flight FIFO contents on a reset mid-operation; handshakes sampled during reset are ignored.
REQ-032 SHALL drive ld_ready = 1 and alu_ready = 1 combinationally during reset.

Verification
REQ-033 ALU write: alu_valid = 1, alu_rd = 5, alu_data = 0xDEADBEEF for one cycle -> next cycle write_enable = 1, write_addr = 5, write_data = 0xDEADBEEF.
REQ-034 Fill: 5 loads presented back-to-back (rd 1..5) with alu_valid held at 1 -> ld_ready = 0 once ld_count = 4, and the 5th load waits.
REQ-035 Starvation: FIFO holds rd = 7 / 0x11 and alu_valid is held at 1 with rd = 3 -> 4 ALU writes, then alu_ready = 0 for one cycle, then a write with addr 7, data 0x11, then ALU writes resume.
REQ-036 x0: ALU rd = 0 with the FIFO holding rd = 9 -> alu_ready = 1, the next write is addr 9, and no write to addr 0 occurs; load rd = 0 -> ld_count unchanged.
REQ-037 Reset mid-operation: FIFO holds 3 entries, rst = 1 for one cycle -> ld_count = 0, write_enable = 0, and no queued entry is ever written.
REQ-038 Full with pop: ld_count = 4 and an ALU idle cycle -> ld_ready = 0 in that cycle, ld_count = 3 the next cycle, and ld_ready = 1.
